// File: rtl/yrv_run_ctrl_pkg.sv
// Shared types, parameter defaults and sizing helper for the YRV run controller.
package yrv_run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        RUN,
        PASS,
        TIMEOUT
    } state_t;

    localparam int RST_HOLD_CYCLES_DEF = 10;
    localparam int TIMEOUT_CYCLES_DEF  = 1000;
    localparam int CNT_W_DEF           = 16;
    localparam int N_IRQ_DEF           = 2;
    localparam int IRQ_PULSE_W_DEF     = 4;

    // Hold-counter width: must represent 0 .. RST_HOLD_CYCLES.
    function automatic int hold_cnt_w(input int hold_cycles);
        return $clog2(hold_cycles + 1);
    endfunction

endpackage

// File: rtl/yrv_irq_pulse_gen.sv
// One interrupt stimulus channel: fixed-width registered pulse, restartable, killed when run drops.
module yrv_irq_pulse_gen #(
    parameter int PULSE_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic trig_i,
    input  logic en_i,
    input  logic run_i,
    output logic pulse_o
);

    localparam int REM_W = $clog2(PULSE_W + 1);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(PULSE_W - 1);

    logic [REM_W-1:0] rem_q, rem_d;
    logic             pulse_q, pulse_d;

    // rem_q counts the high cycles still owed after the current one.
    always_comb begin
        rem_d   = '0;
        pulse_d = 1'b0;
        if (run_i) begin
            if (trig_i && en_i) begin
                rem_d   = REM_INIT;
                pulse_d = 1'b1;
            end else if (pulse_q && (rem_q != '0)) begin
                rem_d   = rem_q - 1'b1;
                pulse_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/yrv_run_ctrl.sv
// YRV MCU run controller: reset sequencing, run-cycle counting, IRQ injection, PASS/TIMEOUT status.
// Optional build macro YRV_RUN_CTRL_DONE_SYNC_EN adds a 2-flop synchronizer on done_in.
module yrv_run_ctrl
    import yrv_run_ctrl_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = RST_HOLD_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF,
    parameter int N_IRQ           = N_IRQ_DEF,
    parameter int IRQ_PULSE_W     = IRQ_PULSE_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   done_in,
    input  logic [N_IRQ-1:0]       irq_en,
    input  logic [N_IRQ*CNT_W-1:0] irq_at,
    output logic                   cpu_resetb,
    output logic [N_IRQ-1:0]       irq_req,
    output logic                   running,
    output logic                   pass,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_cnt
);

    localparam int HOLD_W = hold_cnt_w(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              cpu_resetb_q;
    logic              running_q;
    logic              pass_q;
    logic              timeout_q;
    logic              done_eff;
    logic              run_stay;

`ifdef YRV_RUN_CTRL_DONE_SYNC_EN
    logic [1:0] done_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_sync_q <= 2'b00;
        end else begin
            done_sync_q <= {done_sync_q[0], done_in};
        end
    end

    assign done_eff = done_sync_q[1];
`else
    assign done_eff = done_in;
`endif

    // True when the FSM will still be in RUN after this edge; gates pulses so they die with RUN.
    assign run_stay = (state_q == RUN) && !done_eff && (cnt_q != TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            cnt_q        <= '0;
            cpu_resetb_q <= 1'b0;
            running_q    <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RST_HOLD;
                        hold_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_q      <= RUN;
                        hold_q       <= '0;
                        cpu_resetb_q <= 1'b1;
                        running_q    <= 1'b1;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                RUN: begin
                    if (done_eff) begin
                        state_q   <= PASS;
                        running_q <= 1'b0;
                        pass_q    <= 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= TIMEOUT;
                        running_q <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PASS, TIMEOUT: begin
                    if (start) begin
                        state_q      <= RST_HOLD;
                        hold_q       <= '0;
                        cnt_q        <= '0;
                        cpu_resetb_q <= 1'b0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < N_IRQ; i++) begin : g_irq
        logic trig;
        assign trig = (state_q == RUN) && (cnt_q == irq_at[i*CNT_W +: CNT_W]);

        yrv_irq_pulse_gen #(
            .PULSE_W (IRQ_PULSE_W)
        ) u_pulse (
            .clk     (clk),
            .reset   (reset),
            .trig_i  (trig),
            .en_i    (irq_en[i]),
            .run_i   (run_stay),
            .pulse_o (irq_req[i])
        );
    end

    assign cpu_resetb = cpu_resetb_q;
    assign running    = running_q;
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_yrv_run_ctrl.sv
// Self-checking bench for yrv_run_ctrl (default build) against a run-cycle-indexed reference model.
module tb_yrv_run_ctrl;

    localparam int HOLD  = 10;
    localparam int T     = 1000;
    localparam int CNT_W = 16;
    localparam int N_IRQ = 2;
    localparam int PW    = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic                   done_in;
    logic [N_IRQ-1:0]       irq_en;
    logic [N_IRQ*CNT_W-1:0] irq_at;
    logic                   cpu_resetb;
    logic [N_IRQ-1:0]       irq_req;
    logic                   running;
    logic                   pass;
    logic                   timeout;
    logic [CNT_W-1:0]       cycle_cnt;

    int         checks = 0;
    int         errors = 0;
    int         cur_at [N_IRQ];
    logic [1:0] cur_en;

    yrv_run_ctrl #(
        .RST_HOLD_CYCLES (HOLD),
        .TIMEOUT_CYCLES  (T),
        .CNT_W           (CNT_W),
        .N_IRQ           (N_IRQ),
        .IRQ_PULSE_W     (PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .done_in    (done_in),
        .irq_en     (irq_en),
        .irq_at     (irq_at),
        .cpu_resetb (cpu_resetb),
        .irq_req    (irq_req),
        .running    (running),
        .pass       (pass),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic rb, input logic [1:0] irq,
                             input logic run, input logic p, input logic to,
                             input logic [CNT_W-1:0] cnt);
        check({tag, ".cpu_resetb"}, 32'(cpu_resetb), 32'(rb));
        check({tag, ".irq_req"},    32'(irq_req),    32'(irq));
        check({tag, ".running"},    32'(running),    32'(run));
        check({tag, ".pass"},       32'(pass),       32'(p));
        check({tag, ".timeout"},    32'(timeout),    32'(to));
        check({tag, ".cycle_cnt"},  32'(cycle_cnt),  32'(cnt));
    endtask

    // Channel i is high on run cycles at+1 .. at+PW when enabled; at >= T can never be reached.
    function automatic logic [1:0] model_irq(input int k);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            r[i] = cur_en[i] && (cur_at[i] < k) && (k <= cur_at[i] + PW);
        end
        return r;
    endfunction

    // One full run from IDLE/PASS/TIMEOUT. -1 (or out of range) disables done/start/abort events.
    task automatic do_run(input int at0, input int at1, input logic [1:0] en, input int done_at,
                          input int hold_start, input int run_start, input int abort_at);
        logic p;
        int   cnt_end;
        @(negedge clk);
        cur_at[0] = at0;
        cur_at[1] = at1;
        cur_en    = en;
        irq_at    = {16'(at1), 16'(at0)};
        irq_en    = en;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int h = 0; h < HOLD; h++) begin
            check_all("hold", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
            start = (h == hold_start);
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < T; k++) begin
            check_all("run", 1'b1, model_irq(k), 1'b1, 1'b0, 1'b0, 16'(k));
            if (k == abort_at) begin
                #2 reset = 1'b1;
                #1;
                check_all("async_rst", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
                @(negedge clk);
                reset = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_all("idle_after_rst", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
                end
                return;
            end
            done_in = (k == done_at);
            start   = (k == run_start);
            @(negedge clk);
            done_in = 1'b0;
            start   = 1'b0;
            if (k == done_at || k == T - 1) break;
        end
        p       = (done_at >= 0) && (done_at < T);
        cnt_end = p ? done_at : T - 1;
        repeat (3) begin
            check_all(p ? "pass_end" : "timeout_end", 1'b1, 2'b00, 1'b0, p, !p, 16'(cnt_end));
            @(negedge clk);
        end
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        done_in = 1'b0;
        irq_en  = '0;
        irq_at  = '0;
        #3;
        check_all("reset", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all("idle", 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        end

        do_run(100, 200, 2'b11, -1, 5, -1, -1);
        do_run(100, 200, 2'b01, 300, -1, 150, -1);
        do_run(100, 200, 2'b11, T - 1, -1, -1, -1);
        do_run(100, 200, 2'b10, 250, 9, 0, -1);

        for (int r = 0; r < 4; r++) begin
            do_run(int'($urandom_range(0, 1100)), int'($urandom_range(0, 1100)),
                   2'($urandom_range(0, 3)), int'($urandom_range(0, 1200)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 1100)), -1);
        end

        do_run(497, 200, 2'b01, -1, -1, 300, 500);
        do_run(0, 5, 2'b11, 0, -1, -1, -1);
        do_run(994, 996, 2'b11, -1, -1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
